// File: rtl/cache_types.sv
// Shared cache type definitions: controller/adaptor state enums and address helpers.
package cache_types;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } adaptor_state_t;

    // Clears the low `off` bits so the address points at the start of its line.
    function automatic logic [31:0] align_addr(input logic [31:0] addr, input int unsigned off);
        logic [31:0] mask;
        mask = (32'd1 << off) - 32'd1;
        return addr & ~mask;
    endfunction

endpackage

// File: rtl/cacheline_adaptor.sv
// Converts between the cache's 256-bit line port and the 64-bit burst port of memory,
// one line transaction at a time, with a single-cycle completion pulse back to the cache.
module cacheline_adaptor
    import cache_types::*;
#(
    parameter int s_line    = 256,
    parameter int s_burst   = 64,
    parameter int s_offset  = 5,
    parameter int num_beats = s_line / s_burst
) (
    input  logic                clk,
    input  logic                rst,

    input  logic [s_line-1:0]   line_i,
    output logic [s_line-1:0]   line_o,
    input  logic [31:0]         address_i,
    input  logic                read_i,
    input  logic                write_i,
    output logic                resp_o,

    input  logic [s_burst-1:0]  burst_i,
    output logic [s_burst-1:0]  burst_o,
    output logic [31:0]         address_o,
    output logic                read_o,
    output logic                write_o,
    input  logic                resp_i
);

    localparam int CW = (num_beats > 1) ? $clog2(num_beats) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(num_beats - 1);

    adaptor_state_t    state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [s_line-1:0] rbuf_q, rbuf_d;
    logic [s_line-1:0] wbuf_q, wbuf_d;
    logic [31:0]       addr_q, addr_d;
    logic              read_q, read_d;
    logic              write_q, write_d;
    logic              resp_q, resp_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rbuf_d  = rbuf_q;
        wbuf_d  = wbuf_q;
        addr_d  = addr_q;

        case (state_q)
            IDLE: begin
                // A write outranks a read if the cache ever raises both.
                if (write_i) begin
                    wbuf_d  = line_i;
                    addr_d  = align_addr(address_i, s_offset);
                    cnt_d   = '0;
                    state_d = WR;
                end else if (read_i) begin
                    addr_d  = align_addr(address_i, s_offset);
                    cnt_d   = '0;
                    state_d = RD;
                end
            end
            RD: begin
                if (resp_i) begin
                    rbuf_d[cnt_q*s_burst +: s_burst] = burst_i;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        state_d = DONE;
                    end
                end
            end
            WR: begin
                if (resp_i) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Handshake outputs follow the next state so they come straight off flops.
        read_d  = (state_d == RD);
        write_d = (state_d == WR);
        resp_d  = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rbuf_q  <= '0;
            wbuf_q  <= '0;
            addr_q  <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            resp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rbuf_q  <= rbuf_d;
            wbuf_q  <= wbuf_d;
            addr_q  <= addr_d;
            read_q  <= read_d;
            write_q <= write_d;
            resp_q  <= resp_d;
        end
    end

    // Fill data and writeback data live in separate buffers so a writeback never alters line_o.
    assign line_o    = rbuf_q;
    assign burst_o   = wbuf_q[cnt_q*s_burst +: s_burst];
    assign address_o = addr_q;
    assign read_o    = read_q;
    assign write_o   = write_q;
    assign resp_o    = resp_q;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Randomized bench for cacheline_adaptor against a transaction-level model of line fills and writebacks.
module tb_cacheline_adaptor;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [255:0] line_i = '0;
    logic [255:0] line_o;
    logic [31:0]  address_i = '0;
    logic         read_i = 1'b0;
    logic         write_i = 1'b0;
    logic         resp_o;
    logic [63:0]  burst_i = '0;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i = 1'b0;

    int total = 0;
    int bad   = 0;

    // Model: last completed fill line, and the beat shown on burst_o while idle.
    logic [255:0] m_line = '0;
    logic [63:0]  m_idle_burst = '0;

    cacheline_adaptor dut (
        .clk       (clk),
        .rst       (rst),
        .line_i    (line_i),
        .line_o    (line_o),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .resp_o    (resp_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] rnd_line();
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[k*32 +: 32] = $urandom;
        return l;
    endfunction

    function automatic logic [63:0] rnd_beat();
        return {$urandom, $urandom};
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_read_o"},  read_o,  1'b0);
        chk({tag, "_write_o"}, write_o, 1'b0);
        chk({tag, "_resp_o"},  resp_o,  1'b0);
        chk({tag, "_line_o"},  line_o,  m_line);
        chk({tag, "_burst_o"}, burst_o, m_idle_burst);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_line_o"},    line_o,    256'd0);
        chk({tag, "_burst_o"},   burst_o,   64'd0);
        chk({tag, "_address_o"}, address_o, 32'd0);
        chk({tag, "_read_o"},    read_o,    1'b0);
        chk({tag, "_write_o"},   write_o,   1'b0);
        chk({tag, "_resp_o"},    resp_o,    1'b0);
    endtask

    // pat bit i gives resp_i for the i-th cycle spent waiting; beyond bit 15 memory always answers.
    // abort < 4 asserts rst once that many beats have been delivered.
    task automatic do_read(input logic [31:0] addr, input logic [255:0] beats,
                           input logic [15:0] pat, input int abort);
        int n = 0;
        int i = 0;
        logic [31:0] aexp;
        aexp = {addr[31:5], 5'b0};
        @(negedge clk);
        read_i = 1'b1; write_i = 1'b0; address_i = addr; resp_i = 1'b0;
        while (n < 4) begin
            @(negedge clk);
            if (n == abort) begin
                rst = 1'b1;
                #1;
                check_reset_vals("rst_mid");
                m_line = '0;
                m_idle_burst = '0;
                @(negedge clk);
                rst = 1'b0; read_i = 1'b0; resp_i = 1'b0;
                return;
            end
            chk("rd_read_o",  read_o,  1'b1);
            chk("rd_write_o", write_o, 1'b0);
            chk("rd_resp_o",  resp_o,  1'b0);
            chk("rd_addr_o",  address_o, aexp);
            address_i = $urandom;
            if (i >= 16 || pat[i]) begin
                resp_i = 1'b1;
                burst_i = beats[n*64 +: 64];
                m_line[n*64 +: 64] = beats[n*64 +: 64];
                n++;
            end else begin
                resp_i = 1'b0;
                burst_i = rnd_beat();
            end
            i++;
        end
        @(negedge clk);
        chk("rd_done_resp_o", resp_o, 1'b1);
        chk("rd_done_read_o", read_o, 1'b0);
        chk("rd_done_line_o", line_o, m_line);
        resp_i = 1'($urandom_range(0, 1));
        burst_i = rnd_beat();
        @(negedge clk);
        check_idle("rd_after");
        read_i = 1'b0; resp_i = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [255:0] wline,
                            input logic [15:0] pat, input bit also_read);
        int n = 0;
        int i = 0;
        logic [31:0] aexp;
        aexp = {addr[31:5], 5'b0};
        @(negedge clk);
        write_i = 1'b1; read_i = also_read; line_i = wline; address_i = addr; resp_i = 1'b0;
        while (n < 4) begin
            @(negedge clk);
            chk("wr_write_o", write_o, 1'b1);
            chk("wr_read_o",  read_o,  1'b0);
            chk("wr_resp_o",  resp_o,  1'b0);
            chk("wr_burst_o", burst_o, wline[n*64 +: 64]);
            chk("wr_line_o",  line_o,  m_line);
            chk("wr_addr_o",  address_o, aexp);
            line_i = ~wline;
            burst_i = rnd_beat();
            if (i >= 16 || pat[i]) begin
                resp_i = 1'b1;
                n++;
            end else begin
                resp_i = 1'b0;
            end
            i++;
        end
        m_idle_burst = wline[63:0];
        @(negedge clk);
        chk("wr_done_resp_o",  resp_o,  1'b1);
        chk("wr_done_write_o", write_o, 1'b0);
        chk("wr_done_read_o",  read_o,  1'b0);
        chk("wr_done_line_o",  line_o,  m_line);
        resp_i = 1'($urandom_range(0, 1));
        @(negedge clk);
        check_idle("wr_after");
        write_i = 1'b0; read_i = 1'b0; resp_i = 1'b0;
    endtask

    task automatic stray(input int ncyc);
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            check_idle("stray");
            resp_i = 1'b1;
            burst_i = rnd_beat();
        end
        @(negedge clk);
        check_idle("stray_end");
        resp_i = 1'b0;
    endtask

    initial begin
        logic [255:0] beats;
        logic [255:0] dline;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;

        // Read fill with contiguous beats
        beats = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        do_read(32'h1234_5678, beats, 16'hFFFF, 4);
        chk("t1_addr_o", address_o, 32'h1234_5660);
        chk("t1_line_o", line_o, beats);

        // Writeback; line_o must keep the fill data
        dline = {64'hD3D3_D3D3_0000_0003, 64'hD2D2_D2D2_0000_0002,
                 64'hD1D1_D1D1_0000_0001, 64'hD0D0_D0D0_0000_0000};
        do_write(32'hABCD_EF1F, dline, 16'hFFFF, 1'b0);
        chk("t2_line_o", line_o, beats);

        // Gapped beats 1,0,0,1,1,0,1
        do_read(32'h0000_0040, rnd_line(), 16'h0059, 4);

        // Simultaneous read and write requests
        do_write(32'h8000_0020, rnd_line(), 16'h00A5, 1'b1);

        // Reset after two beats, then a clean read
        do_read(32'h5555_5555, rnd_line(), 16'hFFFF, 2);
        check_idle("post_rst");
        do_read(32'h7777_7777, rnd_line(), 16'h0F0F, 4);

        // Stray responses while idle
        stray(3);

        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 4))
                0, 1: do_read($urandom, rnd_line(), 16'($urandom), 4);
                2:    do_write($urandom, rnd_line(), 16'($urandom), 1'b0);
                3:    do_write($urandom, rnd_line(), 16'($urandom), 1'b1);
                default: stray(int'($urandom_range(1, 3)));
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cacheline_adaptor.md
# cacheline_adaptor

Bridges the cache's 256-bit line interface to the 64-bit burst interface of physical memory. Sits between the cache datapath/controller and main memory. It serialises an evicted dirty line into four 64-bit write beats. It assembles four 64-bit read beats into one fill line. Exactly one line transaction is in flight at a time, and completion is signalled to the cache with a single-cycle response.

## Interface

**Parameters**
- `s_line`, 256: cache line width in bits.
- `s_burst`, 64: memory beat width in bits.
- `s_offset`, 5: line offset bits; the address is aligned by zeroing these bits.
- `num_beats`, `s_line/s_burst` (4): beats per line.

**Ports**
- `clk`  in  1: sole clock; rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `line_i`  in  `s_line`: line to write; sampled on write acceptance.
- `address_i`  in  32: line address from the cache; sampled on acceptance.
- `read_i`  in  1: cache requests a line fill; held until `resp_o`.
- `write_i`  in  1: cache requests a line writeback; held until `resp_o`.
- `line_o`  out  `s_line`: assembled fill line; valid in the `resp_o` cycle and held until the next read starts.
- `resp_o`  out  1: one-cycle completion pulse.
- `burst_i`  in  `s_burst`: read beat from memory; valid when `resp_i` is high.
- `burst_o`  out  `s_burst`: current write beat.
- `address_o`  out  32: aligned line address, `{addr[31:s_offset], 0}`.
- `read_o`  out  1: memory read request.
- `write_o`  out  1: memory write request.
- `resp_i`  in  1: memory accepts or delivers one beat.

## Operation

**States:** `IDLE`, `RD`, `WR`, `DONE`.

**`IDLE`**
- If `write_i` is high: latch `line_i` into the line buffer, latch the aligned `address_i`, clear the beat counter, go to `WR`.
- Else if `read_i` is high: latch the aligned address, clear the counter, go to `RD`.
- If both are high, write wins. This is illegal from the cache, but the behaviour is defined.

**`RD`**
- `read_o` is high.
- On each cycle with `resp_i` high: store `burst_i` into `buffer[cnt*s_burst +: s_burst]` and increment `cnt`.
- On the beat where `cnt == num_beats-1`, go to `DONE`.
- Gaps (cycles with `resp_i` low) are legal; the counter holds.

**`WR`**
- `write_o` is high and `burst_o = buffer[cnt*s_burst +: s_burst]`.
- Each `resp_i` advances `cnt`.
- On the last beat, go to `DONE`.

**`DONE`**
- `resp_o` is high for exactly one cycle, then go to `IDLE`.
- Requests seen in `DONE` are ignored. The cache drops its request in the cycle after `resp_o`.

**Other rules**
- `line_o` is driven from the buffer. It is overwritten only by read beats; a write never disturbs `line_o`.
- `resp_i` seen in `IDLE` or `DONE` is ignored.
- The counter is `$clog2(num_beats)` bits and wraps to 0 after the last beat.

## Timing

**Reset values** (async `rst`): state `IDLE`, `cnt` 0, buffer 0, `line_o` 0, `burst_o` 0, `address_o` 0, `read_o` 0, `write_o` 0, `resp_o` 0.

**Registered outputs**
- `read_o`, `write_o` and `resp_o` are decoded from the state register only, so they have no combinational path from inputs.
- `burst_o` is muxed from registered `buffer` and `cnt`.

**Latency**
- Request sampled in cycle 0 → `read_o`/`write_o` high in cycle 1.
- Final `resp_i` in cycle N → `resp_o` in cycle N+1.
- `read_o`/`write_o` drop in cycle N+1.

**Back-to-back:** with contiguous beats from cycle 2, `resp_o` is in cycle 6 and a new request can be sampled in cycle 7.

**Reset mid-transfer:** return to `IDLE` immediately. Partial beats are discarded and no `resp_o` is issued.

## Structure

- Add `adaptor_state_t` (`IDLE`, `RD`, `WR`, `DONE`) to the shared `cache_types` package, alongside the existing cache enums.
- Single module. The counter and buffer stay inline; no sub-module is warranted.

## Test plan

1. **Read fill:** `read_i`=1, `address_i`=`0x1234_5678`; memory returns beats `0x11..11`, `0x22..22`, `0x33..33`, `0x44..44` on consecutive cycles.
   - `address_o`=`0x1234_5660`.
   - `line_o`=`{0x44..44, 0x33..33, 0x22..22, 0x11..11}`.
   - `resp_o` pulses once, one cycle after beat 4.
2. **Writeback:** `write_i`=1 with `line_i`=`{D3,D2,D1,D0}`; memory asserts `resp_i` for 4 cycles.
   - `burst_o` sequence D0, D1, D2, D3.
   - `write_o` drops with `resp_o`.
   - `line_o` is unchanged.
3. **Gapped beats:** `resp_i` pattern 1,0,0,1,1,0,1.
   - Beats land in slots 0–3 in order.
   - `resp_o` comes the cycle after the 7th pattern cycle.
4. **Simultaneous request:** `read_i`=`write_i`=1 in `IDLE`.
   - `WR` is entered.
   - `read_o` stays 0 throughout.
5. **Reset mid-operation:** assert `rst` after 2 read beats.
   - All outputs return to their reset values asynchronously.
   - A subsequent fresh read completes correctly with `cnt` starting at 0.
6. **Stray response:** `resp_i` pulsed in `IDLE`.
   - No state change, no `resp_o`.
   - The buffer is unchanged.
